// File: rtl/nr_weight_accum.sv
// Weighted-neighbourhood accumulator feeding the noise-reduction divider.
// Produces dividend/divisor per neighbourhood and a centre/valid pair aligned to the quotient.
module nr_weight_accum #(
  parameter int TAPS    = 9,
  parameter int TH_LO   = 8,
  parameter int TH_MID  = 20,
  parameter int TH_HI   = 40,
  parameter int DIV_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        pix_first,
  output logic [15:0] num_out,
  output logic [7:0]  den_out,
  output logic        acc_valid,
  output logic        q_valid,
  output logic [7:0]  center_d,
  output logic        err_sync
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);
  localparam logic [7:0] TH_LO_B  = 8'(TH_LO);
  localparam logic [7:0] TH_MID_B = 8'(TH_MID);
  localparam logic [7:0] TH_HI_B  = 8'(TH_HI);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state, state_next;
  logic [7:0]       center;
  logic [15:0]      acc_num;
  logic [7:0]       acc_den;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       out_center;

  logic             start, add, done, abort;
  logic [7:0]       diff;
  logic [2:0]       weight;
  logic [15:0]      wpix;
  logic [15:0]      num_sum;
  logic [7:0]       den_sum;

  logic [DIV_LAT-1:0] dly_valid;
  logic [7:0]         dly_center [DIV_LAT];

  // Weight is a power of two, so the product is a shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    diff   = (pix_in > center) ? (pix_in - center) : (center - pix_in);
    weight = 3'd0;
    wpix   = 16'd0;
    if (diff <= TH_LO_B) begin
      weight = 3'd4;
      wpix   = {6'd0, pix_in, 2'b00};
    end else if (diff <= TH_MID_B) begin
      weight = 3'd2;
      wpix   = {7'd0, pix_in, 1'b0};
    end else if (diff <= TH_HI_B) begin
      weight = 3'd1;
      wpix   = {8'd0, pix_in};
    end
    num_sum = acc_num + wpix;
    den_sum = acc_den + {5'd0, weight};
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    add        = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pix_valid && pix_first) begin
          start      = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (pix_valid) begin
          if (pix_first) begin
            start = 1'b1;
            abort = 1'b1;
          end else begin
            add = 1'b1;
            if (cnt == LAST_CNT) begin
              done       = 1'b1;
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      center     <= '0;
      acc_num    <= '0;
      acc_den    <= '0;
      cnt        <= '0;
      num_out    <= '0;
      den_out    <= '0;
      out_center <= '0;
      acc_valid  <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      acc_valid <= done;
      err_sync  <= abort;
      if (start) begin
        center  <= pix_in;
        acc_num <= {6'd0, pix_in, 2'b00};
        acc_den <= 8'd4;
        cnt     <= CNT_W'(1);
      end else if (add) begin
        acc_num <= num_sum;
        acc_den <= den_sum;
        cnt     <= cnt + 1'b1;
      end
      if (done) begin
        num_out    <= num_sum;
        den_out    <= den_sum;
        out_center <= center;
      end
    end
  end

  // Free-running alignment pipe; tracks the divider regardless of input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this small delay line is reset so no stale q_valid can escape after reset.
      dly_valid <= '0;
      for (int i = 0; i < DIV_LAT; i++) dly_center[i] <= '0;
    end else begin
      dly_valid[0]  <= acc_valid;
      dly_center[0] <= out_center;
      for (int i = 1; i < DIV_LAT; i++) begin
        dly_valid[i]  <= dly_valid[i-1];
        dly_center[i] <= dly_center[i-1];
      end
    end
  end

  assign q_valid  = dly_valid[DIV_LAT-1];
  assign center_d = dly_center[DIV_LAT-1];

endmodule

// File: tb/tb_nr_weight_accum.sv
// Directed scoreboard bench for nr_weight_accum: expectations queued at drive time,
// compared by a negedge monitor against acc_valid, q_valid and err_sync pulses.
module tb_nr_weight_accum;

  localparam int DIV_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_first;
  logic [15:0] num_out;
  logic [7:0]  den_out;
  logic        acc_valid;
  logic        q_valid;
  logic [7:0]  center_d;
  logic        err_sync;

  nr_weight_accum #(
    .TAPS(9), .TH_LO(8), .TH_MID(20), .TH_HI(40), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_first(pix_first), .num_out(num_out), .den_out(den_out),
    .acc_valid(acc_valid), .q_valid(q_valid), .center_d(center_d),
    .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] num;
    logic [7:0]  den;
    logic [7:0]  q;
  } acc_exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] center;
  } q_exp_t;

  acc_exp_t acc_q[$];
  q_exp_t   q_q[$];
  int       err_q[$];

  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] taps [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the inactive edge.
  always @(negedge clk) begin
    if (acc_valid) begin
      check("acc_pending", int'(acc_q.size() > 0), 1);
      if (acc_q.size() > 0) begin
        acc_exp_t e;
        e = acc_q.pop_front();
        check("acc_cycle", cyc, e.cyc);
        check("num_out", int'(num_out), int'(e.num));
        check("den_out", int'(den_out), int'(e.den));
        if (den_out != 0) check("quotient", int'(num_out / den_out), int'(e.q));
      end
    end
    if (q_valid) begin
      check("q_pending", int'(q_q.size() > 0), 1);
      if (q_q.size() > 0) begin
        q_exp_t e;
        e = q_q.pop_front();
        check("q_cycle", cyc, e.cyc);
        check("center_d", int'(center_d), int'(e.center));
      end
    end
    if (err_sync) begin
      check("err_pending", int'(err_q.size() > 0), 1);
      if (err_q.size() > 0) check("err_cycle", cyc, err_q.pop_front());
    end
  end

  task automatic beat(input logic v, input logic f, input logic [7:0] p);
    pix_valid = v;
    pix_first = f;
    pix_in    = p;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_first = 1'b0;
  endtask

  // Centre beat, then the 8 neighbours in taps[]; optional random idle cycles between taps.
  task automatic send_window(input logic [7:0] c, input logic [15:0] en, input logic [7:0] ed,
                             input logic [7:0] eq, input bit gaps, input bit expect_err);
    if (expect_err) err_q.push_back(cyc + 1);
    beat(1'b1, 1'b1, c);
    for (int i = 0; i < 8; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) beat(1'b0, 1'b1, 8'hAA);
      if (i == 7) begin
        acc_q.push_back('{cyc: cyc + 1, num: en, den: ed, q: eq});
        q_q.push_back('{cyc: cyc + 1 + DIV_LAT, center: c});
      end
      beat(1'b1, 1'b0, taps[i]);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (acc_q.size() == 0 && q_q.size() == 0 && err_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_acc_empty", acc_q.size(), 0);
    check("drain_q_empty", q_q.size(), 0);
    check("drain_err_empty", err_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_num"}, int'(num_out), 0);
    check({tag, "_den"}, int'(den_out), 0);
    check({tag, "_acc_valid"}, int'(acc_valid), 0);
    check({tag, "_q_valid"}, int'(q_valid), 0);
    check({tag, "_center_d"}, int'(center_d), 0);
    check({tag, "_err_sync"}, int'(err_sync), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    pix_in = '0;
    pix_valid = 1'b0;
    pix_first = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray beat in IDLE: silently dropped.
    beat(1'b1, 1'b0, 8'd77);

    // Flat window.
    taps = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    send_window(8'd100, 16'd3600, 8'd36, 8'd100, 1'b0, 1'b0);
    drain();

    // Step edge.
    taps = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd200, 8'd200, 8'd200, 8'd200};
    send_window(8'd50, 16'd1000, 8'd20, 8'd50, 1'b0, 1'b0);
    drain();

    // Graded weights.
    taps = '{8'd105, 8'd110, 8'd130, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    send_window(8'd100, 16'd3170, 8'd31, 8'd102, 1'b0, 1'b0);
    drain();

    // Threshold boundaries on both sides of the centre: d = 8,20,40,41.
    taps = '{8'd108, 8'd120, 8'd140, 8'd141, 8'd92, 8'd80, 8'd60, 8'd59};
    send_window(8'd100, 16'd1800, 8'd18, 8'd100, 1'b0, 1'b0);
    drain();

    // Flat window with random gaps.
    taps = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    send_window(8'd100, 16'd3600, 8'd36, 8'd100, 1'b1, 1'b0);
    drain();

    // Back-to-back: second centre on the cycle after the last tap.
    send_window(8'd100, 16'd3600, 8'd36, 8'd100, 1'b0, 1'b0);
    taps = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd200, 8'd200, 8'd200, 8'd200};
    send_window(8'd50, 16'd1000, 8'd20, 8'd50, 1'b0, 1'b0);
    drain();

    // Abort: partial window at 80, then a new centre 60 restarts.
    beat(1'b1, 1'b1, 8'd80);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 8'd80);
    taps = '{8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 8'd60};
    send_window(8'd60, 16'd2160, 8'd36, 8'd60, 1'b0, 1'b1);
    drain();

    // Reset mid-neighbourhood discards the partial sums.
    beat(1'b1, 1'b1, 8'd100);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 8'd100);
    rst_n = 1'b0;
    #2;
    check_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_zero("midreset_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    taps = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    send_window(8'd100, 16'd3600, 8'd36, 8'd100, 1'b0, 1'b0);
    drain();
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
